// File: rtl/ll_pkg.sv
// Shared types and helpers for the LL/SC reservation tracker.
package ll_pkg;

    // Widest context select and address the helpers below are sized for.
    localparam int MAX_CTX_W  = 3;
    localparam int MAX_ADDR_W = 64;

    // One request from writeback (LL, SC or invalidating store).
    typedef struct packed {
        logic                  valid;
        logic [MAX_CTX_W-1:0]  ctx;
        logic [MAX_ADDR_W-1:0] addr;
    } ll_req_t;

    // Width of a context select: at least one bit even for a single context.
    function automatic int ctx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Width of the age counter: must hold TIMEOUT-1, at least one bit.
    function automatic int age_width(input int t);
        if (t <= 1) begin
            return 1;
        end else begin
            return $clog2(t);
        end
    endfunction

    // Two addresses fall in the same reservation granule.
    function automatic logic gran_eq(input logic [MAX_ADDR_W-1:0] a,
                                     input logic [MAX_ADDR_W-1:0] b,
                                     input int unsigned           lsb);
        return ((a >> lsb) == (b >> lsb));
    endfunction

    // Request targets context c.
    function automatic logic req_hits(input ll_req_t req, input int unsigned c);
        return req.valid && (req.ctx == MAX_CTX_W'(c));
    endfunction

    // Request comes from a legal context other than c.
    function automatic logic req_other(input ll_req_t     req,
                                       input int unsigned c,
                                       input int unsigned n);
        return req.valid && (req.ctx < MAX_CTX_W'(n)) && (req.ctx != MAX_CTX_W'(c));
    endfunction

endpackage

// File: rtl/ll_entry.sv
// One context's reservation: valid bit, granule address and age counter.
module ll_entry
    import ll_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int GRAN_LSB = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ll_set,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic              sc_sel,
    input  logic [ADDR_W-1:0] sc_addr,
    input  logic              inv_sel,
    input  logic [ADDR_W-1:0] inv_addr,
    output logic              valid,
    output logic [ADDR_W-1:0] lladdr,
    output logic              sc_ok
);

    localparam int                 AGE_W     = age_width(TIMEOUT);
    localparam bit                 EXP_EN    = (TIMEOUT > 0);
    localparam logic [AGE_W-1:0]   AGE_LAST  = AGE_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [AGE_W-1:0]   AGE_MAX   = '1;
    localparam logic [ADDR_W-1:0]  GRAN_MASK = ~((ADDR_W'(1) << GRAN_LSB) - ADDR_W'(1));

    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [AGE_W-1:0]  age_r;
    logic              inv_hit_s;
    logic              sc_match_s;
    logic              expire_s;

    // Granule compares, expiry detect and SC verdict on pre-edge state.
    always_comb begin
        inv_hit_s  = inv_sel && gran_eq(MAX_ADDR_W'(inv_addr), MAX_ADDR_W'(addr_r), GRAN_LSB);
        sc_match_s = gran_eq(MAX_ADDR_W'(sc_addr), MAX_ADDR_W'(addr_r), GRAN_LSB);
        expire_s   = EXP_EN && (age_r == AGE_LAST);
        // Flush and a foreign store to our granule both kill the SC this cycle.
        sc_ok      = valid_r && sc_match_s && !flush && !inv_hit_s;
    end

    // Reservation state: flush > LL > SC > invalidate > expiry/ageing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            addr_r  <= '0;
            age_r   <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (ll_set) begin
            valid_r <= 1'b1;
            addr_r  <= ll_addr & GRAN_MASK;
            age_r   <= '0;
        end else if (sc_sel) begin
            valid_r <= 1'b0;
        end else if (inv_hit_s) begin
            valid_r <= 1'b0;
        end else if (valid_r) begin
            if (expire_s) begin
                valid_r <= 1'b0;
            end else if (age_r != AGE_MAX) begin
                age_r <= age_r + AGE_W'(1);
            end else begin
                age_r <= age_r;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid  = valid_r;
    assign lladdr = addr_r;

endmodule

// File: rtl/ll_reserve.sv
// Load-linked / store-conditional reservation tracker for NUM_CTX contexts.
module ll_reserve
    import ll_pkg::*;
#(
    parameter  int NUM_CTX  = 2,
    parameter  int ADDR_W   = 32,
    parameter  int GRAN_LSB = 2,
    parameter  int TIMEOUT  = 255,
    localparam int CTX_W    = ctx_width(NUM_CTX)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CTX-1:0] flush_i,
    input  logic               ll_valid_i,
    input  logic [CTX_W-1:0]   ll_ctx_i,
    input  logic [ADDR_W-1:0]  ll_addr_i,
    input  logic               sc_valid_i,
    input  logic [CTX_W-1:0]   sc_ctx_i,
    input  logic [ADDR_W-1:0]  sc_addr_i,
    input  logic               inv_valid_i,
    input  logic [CTX_W-1:0]   inv_ctx_i,
    input  logic [ADDR_W-1:0]  inv_addr_i,
    input  logic [CTX_W-1:0]   rd_ctx_i,
    output logic               sc_done_o,
    output logic               sc_ok_o,
    output logic [NUM_CTX-1:0] llbit_o,
    output logic               rd_llbit_o,
    output logic [ADDR_W-1:0]  rd_lladdr_o
);

    ll_req_t            ll_req_s;
    ll_req_t            sc_req_s;
    ll_req_t            inv_req_s;
    logic [NUM_CTX-1:0] ll_sel_s;
    logic [NUM_CTX-1:0] sc_sel_s;
    logic [NUM_CTX-1:0] inv_sel_s;
    logic [NUM_CTX-1:0] valid_s;
    logic [NUM_CTX-1:0] ok_s;
    logic [ADDR_W-1:0]  lladdr_s [NUM_CTX];
    logic               sc_done_r;
    logic               sc_ok_r;

    assign ll_req_s  = '{valid: ll_valid_i,  ctx: MAX_CTX_W'(ll_ctx_i),  addr: MAX_ADDR_W'(ll_addr_i)};
    assign sc_req_s  = '{valid: sc_valid_i,  ctx: MAX_CTX_W'(sc_ctx_i),  addr: MAX_ADDR_W'(sc_addr_i)};
    assign inv_req_s = '{valid: inv_valid_i, ctx: MAX_CTX_W'(inv_ctx_i), addr: MAX_ADDR_W'(inv_addr_i)};

    // Out-of-range ctx values match no entry, so they change no state.
    for (genvar c = 0; c < NUM_CTX; c++) begin : g_ctx
        assign ll_sel_s[c]  = req_hits(ll_req_s, c);
        assign sc_sel_s[c]  = req_hits(sc_req_s, c);
        assign inv_sel_s[c] = req_other(inv_req_s, c, NUM_CTX);

        ll_entry #(
            .ADDR_W   (ADDR_W),
            .GRAN_LSB (GRAN_LSB),
            .TIMEOUT  (TIMEOUT)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush_i[c]),
            .ll_set   (ll_sel_s[c]),
            .ll_addr  (ll_addr_i),
            .sc_sel   (sc_sel_s[c]),
            .sc_addr  (sc_addr_i),
            .inv_sel  (inv_sel_s[c]),
            .inv_addr (inv_addr_i),
            .valid    (valid_s[c]),
            .lladdr   (lladdr_s[c]),
            .sc_ok    (ok_s[c])
        );
    end

    // SC result register: one-cycle done pulse, fails for illegal contexts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_done_r <= 1'b0;
            sc_ok_r   <= 1'b0;
        end else begin
            sc_done_r <= sc_valid_i;
            sc_ok_r   <= sc_valid_i && (|(sc_sel_s & ok_s));
        end
    end

    // CP0 read view of the selected context; zero for an illegal select.
    always_comb begin
        rd_llbit_o  = 1'b0;
        rd_lladdr_o = '0;
        for (int c = 0; c < NUM_CTX; c++) begin
            if (rd_ctx_i == CTX_W'(c)) begin
                rd_llbit_o  = valid_s[c];
                rd_lladdr_o = lladdr_s[c];
            end else begin
                rd_llbit_o  = rd_llbit_o;
            end
        end
    end

    assign sc_done_o = sc_done_r;
    assign sc_ok_o   = sc_ok_r;
    assign llbit_o   = valid_s;

endmodule

// File: tb/tb_ll_reserve.sv
// Directed plus randomized bench for ll_reserve against a reservation model.
module tb_ll_reserve;

    localparam int NC = 3;
    localparam int AW = 32;
    localparam int GL = 2;
    localparam int TO = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] flush_i;
    logic          ll_valid_i, sc_valid_i, inv_valid_i;
    logic [CW-1:0] ll_ctx_i, sc_ctx_i, inv_ctx_i, rd_ctx_i;
    logic [AW-1:0] ll_addr_i, sc_addr_i, inv_addr_i;
    logic          sc_done_o, sc_ok_o, rd_llbit_o;
    logic [NC-1:0] llbit_o;
    logic [AW-1:0] rd_lladdr_o;

    int checks = 0;
    int errors = 0;

    // Reference model: per context a valid flag, granule address, cycles alive.
    bit            m_valid [NC];
    logic [AW-1:0] m_addr  [NC];
    int            m_life  [NC];
    bit            m_done;
    bit            m_ok;

    always #5 clk = ~clk;

    ll_reserve #(.NUM_CTX(NC), .ADDR_W(AW), .GRAN_LSB(GL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .ll_valid_i(ll_valid_i), .ll_ctx_i(ll_ctx_i), .ll_addr_i(ll_addr_i),
        .sc_valid_i(sc_valid_i), .sc_ctx_i(sc_ctx_i), .sc_addr_i(sc_addr_i),
        .inv_valid_i(inv_valid_i), .inv_ctx_i(inv_ctx_i), .inv_addr_i(inv_addr_i),
        .rd_ctx_i(rd_ctx_i), .sc_done_o(sc_done_o), .sc_ok_o(sc_ok_o),
        .llbit_o(llbit_o), .rd_llbit_o(rd_llbit_o), .rd_lladdr_o(rd_lladdr_o)
    );

    function automatic bit same_gran(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a >> GL) == (b >> GL);
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_valid[c] = 1'b0;
            m_addr[c]  = '0;
            m_life[c]  = 0;
        end
        m_done = 1'b0;
        m_ok   = 1'b0;
    endtask

    // Apply one clock edge worth of rules to the model from current inputs.
    task automatic model_edge();
        int  s;
        bit  ok;
        bit  inv_kill;
        s  = int'(sc_ctx_i);
        ok = 1'b0;
        if (sc_valid_i && s < NC) begin
            inv_kill = inv_valid_i && int'(inv_ctx_i) < NC && int'(inv_ctx_i) != s
                       && same_gran(inv_addr_i, m_addr[s]);
            ok = m_valid[s] && same_gran(sc_addr_i, m_addr[s]) && !flush_i[s] && !inv_kill;
        end
        m_done = sc_valid_i;
        m_ok   = ok;
        for (int c = 0; c < NC; c++) begin
            inv_kill = inv_valid_i && int'(inv_ctx_i) < NC && int'(inv_ctx_i) != c
                       && same_gran(inv_addr_i, m_addr[c]);
            if (flush_i[c]) begin
                m_valid[c] = 1'b0;
            end else if (ll_valid_i && int'(ll_ctx_i) == c) begin
                m_valid[c] = 1'b1;
                m_addr[c]  = (ll_addr_i >> GL) << GL;
                m_life[c]  = 0;
            end else if (sc_valid_i && s == c) begin
                m_valid[c] = 1'b0;
            end else if (inv_kill) begin
                m_valid[c] = 1'b0;
            end else if (m_valid[c]) begin
                m_life[c]++;
                if (m_life[c] >= TO) m_valid[c] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [NC-1:0] exp_bits;
        for (int c = 0; c < NC; c++) exp_bits[c] = m_valid[c];
        chk("sc_done", AW'(sc_done_o), AW'(m_done));
        chk("sc_ok", AW'(sc_ok_o), AW'(m_ok));
        chk("llbit", AW'(llbit_o), AW'(exp_bits));
        chk("rd_llbit", AW'(rd_llbit_o), AW'(m_valid[rd_ctx_i]));
        chk("rd_lladdr", rd_lladdr_o, m_addr[rd_ctx_i]);
    endtask

    task automatic idle();
        flush_i     = '0;
        ll_valid_i  = 1'b0; ll_ctx_i  = '0; ll_addr_i  = '0;
        sc_valid_i  = 1'b0; sc_ctx_i  = '0; sc_addr_i  = '0;
        inv_valid_i = 1'b0; inv_ctx_i = '0; inv_addr_i = '0;
    endtask

    // Inputs were set at the falling edge; take the rising edge and compare.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        idle();
    endtask

    task automatic do_ll(input int c, input logic [AW-1:0] a);
        ll_valid_i = 1'b1; ll_ctx_i = CW'(c); ll_addr_i = a;
    endtask
    task automatic do_sc(input int c, input logic [AW-1:0] a);
        sc_valid_i = 1'b1; sc_ctx_i = CW'(c); sc_addr_i = a;
    endtask
    task automatic do_inv(input int c, input logic [AW-1:0] a);
        inv_valid_i = 1'b1; inv_ctx_i = CW'(c); inv_addr_i = a;
    endtask

    initial begin
        logic [AW-1:0] pool [4];
        pool[0] = 32'h0000_1000; pool[1] = 32'h0000_1004;
        pool[2] = 32'h0000_2000; pool[3] = 32'h0000_0040;

        // Reset state
        rst_n = 1'b0; rd_ctx_i = '0; idle(); model_reset();
        #12;
        check_all();
        @(negedge clk); rst_n = 1'b1;

        // Basic LL then SC three edges later
        do_ll(0, 32'h1000); cycle();
        cycle(); cycle();
        do_sc(0, 32'h1000); cycle();
        chk("basic_sc_ok", AW'(sc_ok_o), 32'd1);
        chk("basic_llbit0", AW'(llbit_o[0]), 32'd0);

        // Store by another context in the same granule kills the reservation
        do_ll(0, 32'h1000); cycle();
        do_inv(1, 32'h1002); cycle();
        chk("inv_other_llbit0", AW'(llbit_o[0]), 32'd0);
        do_sc(0, 32'h1000); cycle();
        chk("inv_other_sc", AW'(sc_ok_o), 32'd0);

        // Own store leaves the reservation alone
        do_ll(0, 32'h1000); cycle();
        do_inv(0, 32'h1000); cycle();
        chk("inv_own_llbit0", AW'(llbit_o[0]), 32'd1);
        do_sc(0, 32'h1000); cycle();
        chk("inv_own_sc", AW'(sc_ok_o), 32'd1);

        // Expiry after exactly TIMEOUT cycles
        rd_ctx_i = 2'd1;
        do_ll(1, 32'h20); cycle();
        for (int i = 0; i < TO - 1; i++) begin
            chk("expiry_alive", AW'(llbit_o[1]), 32'd1);
            cycle();
        end
        chk("expiry_last", AW'(llbit_o[1]), 32'd1);
        cycle();
        chk("expiry_gone", AW'(llbit_o[1]), 32'd0);
        do_sc(1, 32'h20); cycle();
        chk("expiry_sc", AW'(sc_ok_o), 32'd0);

        // Flush beats SC on ctx0; LL beats store-invalidate on ctx1
        rd_ctx_i = 2'd0;
        do_ll(0, 32'h40); cycle();
        flush_i = 3'b001; do_sc(0, 32'h40); do_ll(1, 32'h80); do_inv(2, 32'h80); cycle();
        chk("flush_sc", AW'(sc_ok_o), 32'd0);
        chk("flush_llbit0", AW'(llbit_o[0]), 32'd0);
        chk("llinv_llbit1", AW'(llbit_o[1]), 32'd1);

        // Same-cycle LL and SC on one context: old reservation judged, new installed
        rd_ctx_i = 2'd2;
        do_ll(2, 32'h100); cycle();
        do_ll(2, 32'h200); do_sc(2, 32'h100); cycle();
        chk("llsc_ok", AW'(sc_ok_o), 32'd1);
        chk("llsc_addr", rd_lladdr_o, 32'h200);

        // Illegal context: no state change, SC still completes and fails
        do_ll(3, 32'h300); do_sc(3, 32'h200); cycle();
        chk("illegal_done", AW'(sc_done_o), 32'd1);
        chk("illegal_ok", AW'(sc_ok_o), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rd_ctx_i = CW'($urandom_range(0, NC - 1));
            if ($urandom_range(0, 9) < 4) do_ll($urandom_range(0, 3), pool[$urandom_range(0, 3)] + AW'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) < 3) do_sc($urandom_range(0, 3), pool[$urandom_range(0, 3)] + AW'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) < 3) do_inv($urandom_range(0, 3), pool[$urandom_range(0, 3)] + AW'($urandom_range(0, 3)));
            if ($urandom_range(0, 19) == 0) flush_i = NC'($urandom_range(1, 7));
            cycle();
        end

        // Asynchronous reset between edges drops reservation and SC result
        rd_ctx_i = 2'd0;
        do_ll(0, 32'h500); do_sc(1, 32'h500); cycle();
        chk("pre_reset_llbit0", AW'(llbit_o[0]), 32'd1);
        do_sc(0, 32'h500);
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        do_ll(0, 32'h500);
        model_edge();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_llbit", AW'(llbit_o), 32'd0);
        chk("async_done", AW'(sc_done_o), 32'd0);
        chk("async_ok", AW'(sc_ok_o), 32'd0);
        @(negedge clk); idle();
        @(negedge clk); rst_n = 1'b1;
        cycle();
        chk("post_reset_done", AW'(sc_done_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
